// File: rtl/chan_est_pkg.sv
// chan_est_pkg: shared constants, state encoding and helpers for the
// pilot-based channel estimator / estimate buffer (chan_est_buffer).
package chan_est_pkg;

  localparam int CE_DATA_SIZE = 16;
  localparam int CE_FFT_SIZE  = 64;

  // BPSK training reference, one bit per subcarrier: 1 = reference is -1
  localparam logic [CE_FFT_SIZE-1:0] TRAIN_SIGN = 64'hA5C3_0F96_1E2D_4B78;

  // Unused subcarriers (DC and the guard band 27..37): 1 = null bin
  localparam logic [CE_FFT_SIZE-1:0] TRAIN_NULL = 64'h0000_003F_F800_0001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_TRAIN2 = 2'd2,
    ST_DATA   = 2'd3
  } state_t;

  // Two's complement negation that maps the most negative value to the most
  // positive one instead of wrapping back onto itself.
  function automatic logic signed [CE_DATA_SIZE-1:0] sat_neg(
    input logic signed [CE_DATA_SIZE-1:0] x
  );
    logic signed [CE_DATA_SIZE-1:0] result;
    if (x == {1'b1, {(CE_DATA_SIZE-1){1'b0}}}) begin
      result = {1'b0, {(CE_DATA_SIZE-1){1'b1}}};
    end else begin
      result = -x;
    end
    return result;
  endfunction

endpackage

// File: rtl/chan_est_ram.sv
// chan_est_ram: simple dual-port estimate store, FFT_SIZE x 2*DATA_SIZE.
// One write port, one read port with a registered read (1-cycle latency).
// The read register holds its value while re_i is low. Contents are not reset.
module chan_est_ram #(
  parameter int DATA_SIZE = 16,
  parameter int FFT_SIZE  = 64,
  parameter int ADDR_W    = $clog2(FFT_SIZE)
) (
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [ADDR_W-1:0]      waddr_i,
  input  logic [2*DATA_SIZE-1:0] wdata_i,
  input  logic                   re_i,
  input  logic [ADDR_W-1:0]      raddr_i,
  output logic [2*DATA_SIZE-1:0] rdata_o
);

  logic [2*DATA_SIZE-1:0] mem_q [FFT_SIZE];
  logic [2*DATA_SIZE-1:0] rdata_q;

  // Write port: store one estimate per enabled cycle
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port: registered read, holds the last word when not enabled
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/chan_est_buffer.sv
// chan_est_buffer: computes H[k] from a BPSK training symbol, stores it, and
// during data symbols pairs every received sample (dividend a) with H[k]
// (divisor b) for the downstream complex divider, at a fixed 1-cycle latency.
// Optional feature macro: CHAN_EST_AVG2_EN -- two training symbols per frame,
// the stored estimate being the average of the two per-symbol estimates.
module chan_est_buffer
  import chan_est_pkg::*;
#(
  parameter int DATA_SIZE = CE_DATA_SIZE,
  parameter int FFT_SIZE  = CE_FFT_SIZE,
  parameter int ADDR_W    = $clog2(FFT_SIZE)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic                 i_sof,
  input  logic [DATA_SIZE-1:0] i_data_i,
  input  logic [DATA_SIZE-1:0] i_data_q,
  output logic                 o_valid,
  output logic [DATA_SIZE-1:0] o_data_a_i,
  output logic [DATA_SIZE-1:0] o_data_a_q,
  output logic [DATA_SIZE-1:0] o_data_b_i,
  output logic [DATA_SIZE-1:0] o_data_b_q,
  output logic [ADDR_W-1:0]    o_index,
  output logic                 o_sym_start,
  output logic                 o_est_ready
);

  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(FFT_SIZE - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic              est_ready_q, est_ready_d;

  logic sof_hit;
  logic train_wr;
  logic data_rd;
  logic t2_rd;
  logic [ADDR_W-1:0] wr_k;

  logic signed [DATA_SIZE-1:0] est_i, est_q;

  logic                   ram_we;
  logic [ADDR_W-1:0]      ram_waddr;
  logic [2*DATA_SIZE-1:0] ram_wdata;
  logic                   ram_re;
  logic [2*DATA_SIZE-1:0] ram_rdata;

  logic                 valid_q;
  logic                 sym_q;
  logic [DATA_SIZE-1:0] a_i_q, a_q_q;
  logic [ADDR_W-1:0]    idx_q;
  logic [DATA_SIZE-1:0] b_i_hold_q, b_q_hold_q;

  // A start-of-frame sample always restarts training as subcarrier 0
  assign sof_hit  = i_valid & i_sof;
  assign train_wr = i_valid & ~i_sof & (state_q == ST_TRAIN);
  assign data_rd  = i_valid & ~i_sof & (state_q == ST_DATA);
`ifdef CHAN_EST_AVG2_EN
  assign t2_rd    = i_valid & ~i_sof & (state_q == ST_TRAIN2);
`else
  assign t2_rd    = 1'b0;
`endif
  assign wr_k     = sof_hit ? '0 : k_q;

  // Per-sample estimate against the BPSK reference; null bins get (1,0)
  always_comb begin
    est_i = i_data_i;
    est_q = i_data_q;
    if (TRAIN_NULL[wr_k]) begin
      est_i = DATA_SIZE'(1);
      est_q = '0;
    end else if (TRAIN_SIGN[wr_k]) begin
      est_i = sat_neg(i_data_i);
      est_q = sat_neg(i_data_q);
    end
  end

  // Next-state logic for the frame FSM, subcarrier counter and ready flag
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    est_ready_d = est_ready_q;
    if (sof_hit) begin
      state_d     = ST_TRAIN;
      k_d         = ADDR_W'(1);
      est_ready_d = 1'b0;
    end else if (i_valid) begin
      case (state_q)
        ST_TRAIN: begin
          k_d = k_q + ADDR_W'(1);
          if (k_q == K_LAST) begin
`ifdef CHAN_EST_AVG2_EN
            state_d = ST_TRAIN2;
`else
            state_d     = ST_DATA;
            est_ready_d = 1'b1;
`endif
          end
        end
`ifdef CHAN_EST_AVG2_EN
        ST_TRAIN2: begin
          k_d = k_q + ADDR_W'(1);
          if (k_q == K_LAST) begin
            state_d     = ST_DATA;
            est_ready_d = 1'b1;
          end
        end
`endif
        ST_DATA: begin
          k_d = k_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Frame FSM state registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      est_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      est_ready_q <= est_ready_d;
    end
  end

`ifdef CHAN_EST_AVG2_EN
  logic                        avg_pend_q;
  logic [ADDR_W-1:0]           avg_k_q;
  logic signed [DATA_SIZE-1:0] h2_i_q, h2_q_q;
  logic signed [DATA_SIZE-1:0] h1_i, h1_q;
  logic signed [DATA_SIZE:0]   sum_i, sum_q;
  logic signed [DATA_SIZE-1:0] avg_i, avg_q;

  // Second-symbol estimate waits one cycle for the registered H1 read.
  // Null bins average (1,0) with (1,0) and therefore remain (1,0).
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      avg_pend_q <= 1'b0;
      avg_k_q    <= '0;
      h2_i_q     <= '0;
      h2_q_q     <= '0;
    end else begin
      avg_pend_q <= t2_rd;
      if (t2_rd) begin
        avg_k_q <= k_q;
        h2_i_q  <= est_i;
        h2_q_q  <= est_q;
      end
    end
  end

  assign h1_i  = ram_rdata[2*DATA_SIZE-1:DATA_SIZE];
  assign h1_q  = ram_rdata[DATA_SIZE-1:0];
  assign sum_i = {h1_i[DATA_SIZE-1], h1_i} + {h2_i_q[DATA_SIZE-1], h2_i_q};
  assign sum_q = {h1_q[DATA_SIZE-1], h1_q} + {h2_q_q[DATA_SIZE-1], h2_q_q};
  assign avg_i = sum_i[DATA_SIZE:1];
  assign avg_q = sum_q[DATA_SIZE:1];
`endif

  // Write-port arbitration: a new training sample beats a stale averaging write
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_k;
    ram_wdata = {est_i, est_q};
    if (sof_hit | train_wr) begin
      ram_we = 1'b1;
`ifdef CHAN_EST_AVG2_EN
    end else if (avg_pend_q) begin
      ram_we    = 1'b1;
      ram_waddr = avg_k_q;
      ram_wdata = {avg_i, avg_q};
`endif
    end
  end

  assign ram_re = data_rd | t2_rd;

  chan_est_ram #(
    .DATA_SIZE (DATA_SIZE),
    .FFT_SIZE  (FFT_SIZE),
    .ADDR_W    (ADDR_W)
  ) u_ram (
    .clk_i   (i_clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (k_q),
    .rdata_o (ram_rdata)
  );

  // Output pipeline aligned with the 1-cycle RAM read; a and index hold between pairs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      valid_q    <= 1'b0;
      sym_q      <= 1'b0;
      a_i_q      <= '0;
      a_q_q      <= '0;
      idx_q      <= '0;
      b_i_hold_q <= '0;
      b_q_hold_q <= '0;
    end else begin
      valid_q <= data_rd;
      sym_q   <= data_rd & (k_q == '0);
      if (data_rd) begin
        a_i_q <= i_data_i;
        a_q_q <= i_data_q;
        idx_q <= k_q;
      end
      if (valid_q) begin
        b_i_hold_q <= ram_rdata[2*DATA_SIZE-1:DATA_SIZE];
        b_q_hold_q <= ram_rdata[DATA_SIZE-1:0];
      end
    end
  end

  // The RAM read register is shared with averaging, so b shows it only on a valid pair
  assign o_data_b_i  = valid_q ? ram_rdata[2*DATA_SIZE-1:DATA_SIZE] : b_i_hold_q;
  assign o_data_b_q  = valid_q ? ram_rdata[DATA_SIZE-1:0] : b_q_hold_q;
  assign o_valid     = valid_q;
  assign o_sym_start = sym_q;
  assign o_data_a_i  = a_i_q;
  assign o_data_a_q  = a_q_q;
  assign o_index     = idx_q;
  assign o_est_ready = est_ready_q;

endmodule

// File: tb/tb_chan_est_buffer.sv
// tb_chan_est_buffer: directed self-checking bench for chan_est_buffer.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_chan_est_buffer;
  import chan_est_pkg::*;

  localparam int DW = 16;
  localparam int N  = 64;
  localparam int AW = 6;

  logic          clk;
  logic          reset;
  logic          iValid;
  logic          iSof;
  logic [DW-1:0] iDataI, iDataQ;
  logic          oValid;
  logic [DW-1:0] oAI, oAQ, oBI, oBQ;
  logic [AW-1:0] oIndex;
  logic          oSymStart;
  logic          oEstReady;

  int assertCount = 0;
  int failCount   = 0;

  chan_est_buffer #(.DATA_SIZE(DW), .FFT_SIZE(N), .ADDR_W(AW)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_valid     (iValid),
    .i_sof       (iSof),
    .i_data_i    (iDataI),
    .i_data_q    (iDataQ),
    .o_valid     (oValid),
    .o_data_a_i  (oAI),
    .o_data_a_q  (oAQ),
    .o_data_b_i  (oBI),
    .o_data_b_q  (oBQ),
    .o_index     (oIndex),
    .o_sym_start (oSymStart),
    .o_est_ready (oEstReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected H[k] after the main training pattern: Y=(1000,-200) everywhere
  // except bin 3 (a sign=1 bin), which carries Y=(-32768,5) -> H=(32767,-5).
  function automatic logic [2*DW-1:0] expH(input int k);
    logic [2*DW-1:0] h;
    if (TRAIN_NULL[k]) h = {16'sd1, 16'sd0};
    else if (k == 3) h = {16'sd32767, -16'sd5};
    else if (TRAIN_SIGN[k]) h = {-16'sd1000, 16'sd200};
    else h = {16'sd1000, -16'sd200};
    return h;
  endfunction

  // Drive one cycle of input, then step to just after the capturing edge
  task automatic applyStimulus(input logic v, input logic s,
                               input logic [DW-1:0] di, input logic [DW-1:0] dq);
    iValid = v;
    iSof   = s;
    iDataI = di;
    iDataQ = dq;
    @(posedge clk);
    #1;
    iValid = 1'b0;
    iSof   = 1'b0;
  endtask

  // One training symbol; o_valid stays low and o_est_ready rises only at the end if requested
  task automatic trainSymbol(input logic withSof, input logic [DW-1:0] yi, input logic [DW-1:0] yq,
                             input logic useSpecial, input logic readyAtEnd);
    for (int k = 0; k < N; k++) begin
      if (useSpecial && k == 3) applyStimulus(1'b1, withSof && k == 0, 16'h8000, 16'd5);
      else applyStimulus(1'b1, withSof && k == 0, yi, yq);
      assertCount++;
      if (oValid !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL train_valid k=%0d got %b want 0", k, oValid);
      end
      assertCount++;
      if (oEstReady !== (readyAtEnd && k == N - 1)) begin
        failCount++;
        $display("[TB] FAIL train_ready k=%0d got %b want %b", k, oEstReady, readyAtEnd && k == N - 1);
      end
    end
  endtask

  // Full main training sequence (one or two symbols depending on the build)
  task automatic trainMain();
`ifdef CHAN_EST_AVG2_EN
    trainSymbol(1'b1, 16'd1000, -16'sd200, 1'b1, 1'b0);
    trainSymbol(1'b0, 16'd1000, -16'sd200, 1'b1, 1'b1);
`else
    trainSymbol(1'b1, 16'd1000, -16'sd200, 1'b1, 1'b1);
`endif
  endtask

  // Reset values of every output
  task automatic test_reset();
    reset = 1'b1; iValid = 1'b0; iSof = 1'b0; iDataI = '0; iDataQ = '0;
    repeat (3) @(posedge clk);
    #1;
    assertCount++;
    if ({oValid, oSymStart, oEstReady} !== 3'b000) begin
      failCount++;
      $display("[TB] FAIL reset_flags got %b want 000", {oValid, oSymStart, oEstReady});
    end
    assertCount++;
    if ({oAI, oAQ, oBI, oBQ, oIndex} !== '0) begin
      failCount++;
      $display("[TB] FAIL reset_data got a=%h,%h b=%h,%h idx=%0d want all 0", oAI, oAQ, oBI, oBQ, oIndex);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One data symbol of Y=(300,400) checked against the stored estimate
  task automatic test_data();
    for (int k = 0; k < N; k++) begin
      applyStimulus(1'b1, 1'b0, 16'd300, 16'd400);
      assertCount++;
      if (oValid !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL data_valid k=%0d got %b want 1", k, oValid);
      end
      assertCount++;
      if ({oAI, oAQ} !== {16'd300, 16'd400}) begin
        failCount++;
        $display("[TB] FAIL data_a k=%0d got %0d,%0d want 300,400", k, $signed(oAI), $signed(oAQ));
      end
      assertCount++;
      if ({oBI, oBQ} !== expH(k)) begin
        failCount++;
        $display("[TB] FAIL data_b k=%0d got %h want %h", k, {oBI, oBQ}, expH(k));
      end
      assertCount++;
      if (oIndex !== AW'(k) || oSymStart !== (k == 0)) begin
        failCount++;
        $display("[TB] FAIL data_idx k=%0d got idx=%0d sym=%b want idx=%0d sym=%b", k, oIndex, oSymStart, k, k == 0);
      end
    end
  endtask

  // Three data symbols with random input gaps; output follows input exactly
  task automatic test_gaps();
    int nIn, nOut, nSym, expIdx;
    logic v;
    logic [DW-1:0] di, dq, lastI, lastQ;
    nIn = 0; nOut = 0; nSym = 0; expIdx = 0;
    lastI = 16'd300; lastQ = 16'd400;
    for (int c = 0; c < 2000 && nIn < 3 * N; c++) begin
      v  = 1'($urandom_range(0, 1));
      di = 16'(expIdx * 10);
      dq = 16'(-expIdx);
      applyStimulus(v, 1'b0, di, dq);
      if (oValid === 1'b1) nOut++;
      if (oSymStart === 1'b1) nSym++;
      assertCount++;
      if (oValid !== v) begin
        failCount++;
        $display("[TB] FAIL gap_valid step=%0d got %b want %b", c, oValid, v);
      end
      if (v) begin
        assertCount++;
        if ({oAI, oAQ} !== {di, dq} || {oBI, oBQ} !== expH(expIdx) ||
            oIndex !== AW'(expIdx) || oSymStart !== (expIdx == 0)) begin
          failCount++;
          $display("[TB] FAIL gap_pair k=%0d got a=%h,%h b=%h idx=%0d sym=%b want a=%h,%h b=%h idx=%0d sym=%b",
                   expIdx, oAI, oAQ, {oBI, oBQ}, oIndex, oSymStart, di, dq, expH(expIdx), expIdx, expIdx == 0);
        end
        lastI = di; lastQ = dq;
        nIn++;
        expIdx = (expIdx + 1) % N;
      end else begin
        assertCount++;
        if ({oAI, oAQ} !== {lastI, lastQ} || oSymStart !== 1'b0) begin
          failCount++;
          $display("[TB] FAIL gap_hold step=%0d got a=%h,%h sym=%b want a=%h,%h sym=0", c, oAI, oAQ, oSymStart, lastI, lastQ);
        end
      end
    end
    assertCount++;
    if (nIn !== 3 * N || nOut !== nIn) begin
      failCount++;
      $display("[TB] FAIL gap_count got in=%0d out=%0d want %0d each", nIn, nOut, 3 * N);
    end
    assertCount++;
    if (nSym !== 3 || expIdx !== 0) begin
      failCount++;
      $display("[TB] FAIL gap_symstart got %0d want 3 (end idx %0d want 0)", nSym, expIdx);
    end
  endtask

  // i_sof at k=20 of a data symbol, then reset at training k=30, then recovery
  task automatic test_restart_and_reset();
    for (int k = 0; k < 20; k++) applyStimulus(1'b1, 1'b0, 16'd1, 16'd2);
    applyStimulus(1'b1, 1'b1, 16'd1000, -16'sd200);
    assertCount++;
    if (oValid !== 1'b0 || oEstReady !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL sof_restart got valid=%b ready=%b want 0,0", oValid, oEstReady);
    end
    for (int k = 1; k < 30; k++) begin
      applyStimulus(1'b1, 1'b0, 16'd1000, -16'sd200);
      assertCount++;
      if (oValid !== 1'b0 || oEstReady !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL retrain k=%0d got valid=%b ready=%b want 0,0", k, oValid, oEstReady);
      end
    end
    iValid = 1'b1; iDataI = 16'd1000; iDataQ = -16'sd200;
    reset = 1'b1;
    #1;
    assertCount++;
    if ({oValid, oSymStart, oEstReady, oAI, oAQ, oBI, oBQ, oIndex} !== '0) begin
      failCount++;
      $display("[TB] FAIL midreset got valid=%b ready=%b a=%h,%h b=%h,%h idx=%0d want all 0",
               oValid, oEstReady, oAI, oAQ, oBI, oBQ, oIndex);
    end
    iValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b0, 16'd7, 16'd7);
      assertCount++;
      if (oValid !== 1'b0 || oEstReady !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL idle_nosof k=%0d got valid=%b ready=%b want 0,0", k, oValid, oEstReady);
      end
    end
    trainMain();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 16'd5, 16'd6);
      assertCount++;
      if (oValid !== 1'b1 || oIndex !== AW'(k) || {oBI, oBQ} !== expH(k)) begin
        failCount++;
        $display("[TB] FAIL recover k=%0d got valid=%b idx=%0d b=%h want 1,%0d,%h", k, oValid, oIndex, {oBI, oBQ}, k, expH(k));
      end
    end
  endtask

`ifdef CHAN_EST_AVG2_EN
  // Two-symbol averaging: (100,-3) then (201,-4); ready only after 128 samples
  task automatic test_avg2();
    logic [2*DW-1:0] want [4];
    want[0] = {16'sd1, 16'sd0};
    want[1] = {16'sd150, -16'sd4};
    want[2] = {16'sd150, -16'sd4};
    want[3] = {-16'sd151, 16'sd3};
    trainSymbol(1'b1, 16'd100, -16'sd3, 1'b0, 1'b0);
    trainSymbol(1'b0, 16'd201, -16'sd4, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 16'd9, 16'd9);
      assertCount++;
      if (oValid !== 1'b1 || {oBI, oBQ} !== want[k]) begin
        failCount++;
        $display("[TB] FAIL avg2_b k=%0d got valid=%b b=%h want 1,%h", k, oValid, {oBI, oBQ}, want[k]);
      end
    end
  endtask
`endif

  initial begin
    $display("[TB] chan_est_buffer directed test start");
    test_reset();
    trainMain();
    test_data();
    test_gaps();
    test_restart_and_reset();
`ifdef CHAN_EST_AVG2_EN
    test_avg2();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
